pad_in_debounce: RTL and testbench

PAD_IN_DEBOUNCE -- requirements
Module: pad_in_debounce

---
 rtl/pad_in_debounce.sv | 153 +++++++++++++++
 tb/tb_pad_in_debounce.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_in_debounce.sv
// rtl/pad_in_debounce.sv - pad input synchronizer and debouncer with edge pulses and glitch counter
module pad_in_debounce #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter logic        RESET_LEVEL     = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       c_in,
   input  logic       en,
   input  logic       glitch_clr,
   output logic       level_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic [7:0] glitch_cnt
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic {
      STABLE = 1'b0,
      QUAL   = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_chain_q, sync_chain_d;
   logic                   sync_q;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic [7:0]             glitch_q, glitch_d;

   // Set when the candidate level has been seen for enough consecutive samples.
   logic                   accept;
   // Set when a qualification run is broken by the input returning to level_out.
   logic                   glitch_inc;

   // The only consumer of c_in: shift it into the synchronizer chain every cycle,
   // independent of en, so the chain is always settled when en is raised.
   always_comb begin
      sync_chain_d = {sync_chain_q[SYNC_STAGES-2:0], c_in};
   end

   assign sync_q = sync_chain_q[SYNC_STAGES-1];

   // Synchronizer register; flops come out of reset at the configured pad level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         sync_chain_q <= sync_chain_d;
      end
   end

   // Debounce FSM: decide next state, qualification count and whether to accept.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      glitch_inc = 1'b0;

      if (!en) begin
         // Disabling drops any candidate silently; it is not a rejected transition.
         state_d = STABLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            STABLE: begin
               if (sync_q != level_q) begin
                  if (DEBOUNCE_CYCLES == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = QUAL;
                     cnt_d   = CNT_ONE;
                  end
               end
            end
            QUAL: begin
               if (sync_q != level_q) begin
                  if (cnt_q == CNT_LAST) begin
                     accept  = 1'b1;
                     cnt_d   = '0;
                     state_d = STABLE;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end else begin
                  cnt_d      = '0;
                  state_d    = STABLE;
                  glitch_inc = 1'b1;
               end
            end
            default: begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Level and edge pulses: pulses are registered alongside the new level so they
   // coincide with the first cycle it is visible and can never both be high.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (accept) begin
         level_d = ~level_q;
         rise_d  = ~level_q;
         fall_d  = level_q;
      end
   end

   // Glitch counter: clear takes priority over an increment in the same cycle,
   // and the count sticks at 255 instead of wrapping.
   always_comb begin
      glitch_d = glitch_q;
      if (glitch_clr) begin
         glitch_d = 8'd0;
      end else if (glitch_inc && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   // FSM, counter and output registers; reset discards any candidate in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= STABLE;
         cnt_q    <= '0;
         level_q  <= RESET_LEVEL;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_pad_in_debounce.sv
// tb/tb_pad_in_debounce.sv - scoreboard bench for pad_in_debounce
module tb_pad_in_debounce;

   typedef struct {
      bit rise;
      int at;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       c_in, en, glitch_clr;
   logic       a_level, a_rise, a_fall;
   logic [7:0] a_glitch;
   logic       c_in_b, en_b, glitch_clr_b;
   logic       b_level, b_rise, b_fall;
   logic [7:0] b_glitch;

   int   ecnt = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   ev_t  qa[$];
   ev_t  qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) ecnt <= ecnt + 1;

   pad_in_debounce u_dut (
      .clk(clk), .rst_n(rst_n), .c_in(c_in), .en(en), .glitch_clr(glitch_clr),
      .level_out(a_level), .rise_pulse(a_rise), .fall_pulse(a_fall), .glitch_cnt(a_glitch)
   );

   pad_in_debounce #(.DEBOUNCE_CYCLES(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .c_in(c_in_b), .en(en_b), .glitch_clr(glitch_clr_b),
      .level_out(b_level), .rise_pulse(b_rise), .fall_pulse(b_fall), .glitch_cnt(b_glitch)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
      end
   endtask

   task automatic push_a(input bit rise, input int at);
      ev_t e;
      e.rise = rise;
      e.at   = at;
      qa.push_back(e);
   endtask

   task automatic push_b(input bit rise, input int at);
      ev_t e;
      e.rise = rise;
      e.at   = at;
      qb.push_back(e);
   endtask

   // c_in high for 10 samples then low; optional glitch_clr on the increment edge.
   task automatic do_glitch(input bit clr);
      c_in = 1'b1;
      tick(10);
      c_in = 1'b0;
      tick(2);
      glitch_clr = clr;
      tick(1);
      glitch_clr = 1'b0;
      tick(2);
   endtask

   // Monitor for the default-parameter instance.
   always @(negedge clk) begin
      if (a_rise || a_fall) begin
         ev_t e;
         n_tests++;
         if (a_rise && a_fall) begin
            n_fail++;
            $display("FAIL a_both_pulses: rise=%0b fall=%0b expected one-hot", a_rise, a_fall);
         end else if (qa.size() == 0) begin
            n_fail++;
            $display("FAIL a_unexpected_pulse: rise=%0b fall=%0b at edge %0d expected none", a_rise, a_fall, ecnt);
         end else begin
            e = qa.pop_front();
            if (e.rise != a_rise || e.at != ecnt || a_level != a_rise) begin
               n_fail++;
               $display("FAIL a_pulse: rise=%0b edge=%0d level=%0b expected rise=%0b edge=%0d",
                        a_rise, ecnt, a_level, e.rise, e.at);
            end
         end
      end
   end

   // Monitor for the single-cycle-debounce instance.
   always @(negedge clk) begin
      if (b_rise || b_fall) begin
         ev_t e;
         n_tests++;
         if (b_rise && b_fall) begin
            n_fail++;
            $display("FAIL b_both_pulses: rise=%0b fall=%0b expected one-hot", b_rise, b_fall);
         end else if (qb.size() == 0) begin
            n_fail++;
            $display("FAIL b_unexpected_pulse: rise=%0b fall=%0b at edge %0d expected none", b_rise, b_fall, ecnt);
         end else begin
            e = qb.pop_front();
            if (e.rise != b_rise || e.at != ecnt || b_level != b_rise) begin
               n_fail++;
               $display("FAIL b_pulse: rise=%0b edge=%0d level=%0b expected rise=%0b edge=%0d",
                        b_rise, ecnt, b_level, e.rise, e.at);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      rst_n = 1'b0; c_in = 1'b0; en = 1'b1; glitch_clr = 1'b0;
      c_in_b = 1'b0; en_b = 1'b1; glitch_clr_b = 1'b0;
      tick(2);
      chk("reset_level", a_level, 0);
      chk("reset_rise", a_rise, 0);
      chk("reset_fall", a_fall, 0);
      chk("reset_glitch", a_glitch, 0);
      chk("reset_level_b", b_level, 0);
      rst_n = 1'b1;
      tick(2);

      // single-sample debounce: 3-edge latency, single-cycle pulse accepted
      e0 = ecnt; c_in_b = 1'b1; push_b(1'b1, e0 + 3);
      tick(2); chk("b_rise_early", b_level, 0);
      tick(1); chk("b_rise_level", b_level, 1);
      tick(2);
      e0 = ecnt; c_in_b = 1'b0; push_b(1'b0, e0 + 3);
      tick(3); chk("b_fall_level", b_level, 0);
      tick(2);
      e0 = ecnt; c_in_b = 1'b1; tick(1); c_in_b = 1'b0;
      push_b(1'b1, e0 + 3); push_b(1'b0, e0 + 4);
      tick(6); chk("b_short_pulse_level", b_level, 0);

      // default: 18-edge rise latency
      e0 = ecnt; c_in = 1'b1; push_a(1'b1, e0 + 18);
      tick(17); chk("rise_not_yet", a_level, 0);
      tick(1);  chk("rise_level", a_level, 1);
      chk("rise_glitch", a_glitch, 0);
      tick(3);
      e0 = ecnt; c_in = 1'b0; push_a(1'b0, e0 + 18);
      tick(18); chk("fall_level", a_level, 0);
      tick(2);

      // rejected transitions and saturation
      do_glitch(1'b0);
      chk("glitch_one", a_glitch, 1);
      chk("glitch_level", a_level, 0);
      for (int i = 0; i < 299; i++) do_glitch(1'b0);
      chk("glitch_sat", a_glitch, 255);
      glitch_clr = 1'b1; tick(1); glitch_clr = 1'b0;
      chk("glitch_clr", a_glitch, 0);
      for (int i = 0; i < 5; i++) do_glitch(1'b0);
      chk("glitch_five", a_glitch, 5);
      do_glitch(1'b1);
      chk("glitch_clr_wins", a_glitch, 0);

      // en=0 holds everything; raising en qualifies from scratch
      en = 1'b0; c_in = 1'b1;
      tick(40); chk("en_hold_level", a_level, 0);
      e0 = ecnt; en = 1'b1; push_a(1'b1, e0 + 16);
      tick(15); chk("en_rise_not_yet", a_level, 0);
      tick(1);  chk("en_rise_level", a_level, 1);
      tick(2);
      c_in = 1'b0; tick(8);
      en = 1'b0; tick(3);
      chk("en_abandon_glitch", a_glitch, 0);
      chk("en_abandon_level", a_level, 1);
      e0 = ecnt; en = 1'b1; push_a(1'b0, e0 + 16);
      tick(16); chk("en_fall_level", a_level, 0);
      tick(2);

      // reset mid-qualification at cnt=9
      do_glitch(1'b0);
      chk("pre_reset_glitch", a_glitch, 1);
      c_in = 1'b1; tick(11);
      rst_n = 1'b0; #1;
      chk("mid_reset_level", a_level, 0);
      chk("mid_reset_rise", a_rise, 0);
      chk("mid_reset_fall", a_fall, 0);
      chk("mid_reset_glitch", a_glitch, 0);
      tick(2);
      e0 = ecnt; rst_n = 1'b1; push_a(1'b1, e0 + 18);
      tick(17); chk("post_reset_not_yet", a_level, 0);
      tick(1);  chk("post_reset_level", a_level, 1);
      tick(5);

      chk("pending_a", qa.size(), 0);
      chk("pending_b", qb.size(), 0);
      chk("b_glitch", b_glitch, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
